// File: rtl/b1_preadd_cascade.sv
`timescale 1ns/1ps
// B1 stage of the DSP48A1 B path: optional 18-bit pre-adder on D and B0, B1 register, BCOUT cascade.
// Macro PREADD_SUB_EN builds the subtract path selected by OPMODE[1]; undefined = add only.
module b1_preadd_cascade #(
    parameter int DREG      = 1,
    parameter int B1REG     = 1,
    parameter int OPMODEREG = 1
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        CED,
    input  logic        CEB,
    input  logic        CEOPMODE,
    input  logic [1:0]  OPMODE,
    input  logic [17:0] B_MUX0,
    input  logic [17:0] DIN,
    input  logic        IN_VLD,
    output logic [17:0] B_MUX1,
    output logic [17:0] BCOUT,
    output logic        BCOUT_VLD
);

    localparam int DATA_W = 18;

    logic [DATA_W-1:0] r_qd_p0;
    logic [1:0]        r_qop_p0;
    logic [DATA_W-1:0] r_qb1_p1;
    logic              r_vld_p1;

    logic [DATA_W-1:0] w_qd;
    logic [1:0]        w_qop;
    logic              w_sub;
    logic [DATA_W-1:0] w_pre;
    logic [DATA_W-1:0] w_qb1;
    logic              w_qv;

    // Modulo-2^18 pre-add/subtract; carry and borrow are discarded by the return width.
    function automatic logic [DATA_W-1:0] preadd_wrap(
        input logic [DATA_W-1:0] d,
        input logic [DATA_W-1:0] b,
        input logic              en,
        input logic              sub
    );
        if (!en) begin
            return b;
        end else if (sub) begin
            return d - b;
        end else begin
            return d + b;
        end
    endfunction

    // Stage p0: D and opmode registers
    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            r_qd_p0 <= '0;
        end else if (CED) begin
            r_qd_p0 <= DIN;
        end
    end

    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            r_qop_p0 <= '0;
        end else if (CEOPMODE) begin
            r_qop_p0 <= OPMODE;
        end
    end

    assign w_qd  = (DREG != 0)      ? r_qd_p0  : DIN;
    assign w_qop = (OPMODEREG != 0) ? r_qop_p0 : OPMODE;

`ifdef PREADD_SUB_EN
    assign w_sub = w_qop[1];
`else
    // Subtract bit is still registered for reset compatibility but masked off here.
    assign w_sub = w_qop[1] & 1'b0;
`endif

    assign w_pre = preadd_wrap(w_qd, B_MUX0, w_qop[0], w_sub);

    // Stage p1: B1 register; data and valid share CEB so they never diverge
    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            r_qb1_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else if (CEB) begin
            r_qb1_p1 <= w_pre;
            r_vld_p1 <= IN_VLD;
        end
    end

    assign w_qb1 = (B1REG != 0) ? r_qb1_p1 : w_pre;
    assign w_qv  = (B1REG != 0) ? r_vld_p1 : IN_VLD;

    assign B_MUX1    = w_qb1;
    assign BCOUT     = w_qb1;
    assign BCOUT_VLD = w_qv;

endmodule

// File: tb/tb_b1_preadd_cascade.sv
`timescale 1ns/1ps
// Directed and randomized checks of b1_preadd_cascade against an arithmetic reference model.
module tb_b1_preadd_cascade;

`ifdef PREADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ced = 1'b0, ceb = 1'b0, ceop = 1'b0;
    logic [1:0]  opmode = 2'b00;
    logic [17:0] bmux0 = '0, din = '0;
    logic        invld = 1'b0;

    logic [17:0] r_bmux1, r_bcout, c_bmux1, c_bcout;
    logic        r_vld, c_vld;

    int checks = 0;
    int errors = 0;

    // Reference state for the fully registered instance.
    logic [17:0] m_d, m_b1;
    logic [1:0]  m_op;
    logic        m_v;

    always #5 clk = ~clk;

    b1_preadd_cascade #(.DREG(1), .B1REG(1), .OPMODEREG(1)) u_reg (
        .CLK(clk), .RSTB(rst), .CED(ced), .CEB(ceb), .CEOPMODE(ceop),
        .OPMODE(opmode), .B_MUX0(bmux0), .DIN(din), .IN_VLD(invld),
        .B_MUX1(r_bmux1), .BCOUT(r_bcout), .BCOUT_VLD(r_vld)
    );

    b1_preadd_cascade #(.DREG(0), .B1REG(0), .OPMODEREG(0)) u_comb (
        .CLK(clk), .RSTB(rst), .CED(ced), .CEB(ceb), .CEOPMODE(ceop),
        .OPMODE(opmode), .B_MUX0(bmux0), .DIN(din), .IN_VLD(invld),
        .B_MUX1(c_bmux1), .BCOUT(c_bcout), .BCOUT_VLD(c_vld)
    );

    function automatic logic [17:0] ref_pre(input logic [17:0] d, input logic [17:0] b,
                                            input logic [1:0] op);
        longint r;
        if (!op[0])                r = longint'(b);
        else if (op[1] && SUB_EN)  r = longint'(d) - longint'(b);
        else                       r = longint'(d) + longint'(b);
        r = r % 262144;
        if (r < 0) r = r + 262144;
        return 18'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, settle 1ns.
    task automatic tick();
        logic [17:0] nb1;
        logic        nv;
        @(posedge clk);
        if (rst) begin
            m_d = '0; m_op = '0; m_b1 = '0; m_v = 1'b0;
        end else begin
            nb1 = ceb ? ref_pre(m_d, bmux0, m_op) : m_b1;
            nv  = ceb ? invld : m_v;
            if (ced)  m_d  = din;
            if (ceop) m_op = opmode;
            m_b1 = nb1;
            m_v  = nv;
        end
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_reg_bcout"}, 32'(r_bcout), 32'(m_b1));
        chk({tag, "_reg_bmux1"}, 32'(r_bmux1), 32'(m_b1));
        chk({tag, "_reg_vld"},   32'(r_vld),   32'(m_v));
        chk({tag, "_comb_bcout"}, 32'(c_bcout), 32'(ref_pre(din, bmux0, opmode)));
        chk({tag, "_comb_bmux1"}, 32'(c_bmux1), 32'(ref_pre(din, bmux0, opmode)));
        chk({tag, "_comb_vld"},   32'(c_vld),   32'(invld));
    endtask

    initial begin
        m_d = '0; m_op = '0; m_b1 = '0; m_v = 1'b0;

        // Reset state
        tick();
        chk("reset_bcout", 32'(r_bcout), 32'h0);
        chk("reset_vld",   32'(r_vld),   32'h0);

        // Load a word, then assert reset asynchronously between edges
        rst = 1'b0;
        din = 18'h12345; bmux0 = 18'h00001; invld = 1'b1;
        ced = 1'b1; ceb = 1'b1; ceop = 1'b1; opmode = 2'b00;
        tick();
        chk_all("preload");
        #2 rst = 1'b1;
        m_d = '0; m_op = '0; m_b1 = '0; m_v = 1'b0;
        #1;
        chk("async_rst_bcout", 32'(r_bcout), 32'h0);
        chk("async_rst_vld",   32'(r_vld),   32'h0);
        tick();
        chk("rst_hold_bcout", 32'(r_bcout), 32'h0);
        chk("rst_hold_vld",   32'(r_vld),   32'h0);
        chk_all("rst_hold");

        // Pass-through, one edge of latency
        rst = 1'b0;
        opmode = 2'b00; bmux0 = 18'h2AAAA; invld = 1'b1;
        tick();
        chk("pass_bcout", 32'(r_bcout), 32'h2AAAA);
        chk("pass_vld",   32'(r_vld),   32'h1);
        chk_all("pass");

        // Add with wrap, two edges from DIN/OPMODE
        din = 18'h3FFFF; bmux0 = 18'h00001; opmode = 2'b01;
        tick();
        chk_all("addwrap_e1");
        tick();
        chk("addwrap_bcout", 32'(r_bcout), 32'h00000);
        chk_all("addwrap_e2");

        // Subtract with wrap (or add when the subtracter is not built)
        din = 18'h00000; bmux0 = 18'h00001; opmode = 2'b11;
        tick();
        tick();
        chk("sub_bcout", 32'(r_bcout), SUB_EN ? 32'h3FFFF : 32'h00001);
        chk_all("sub");

        // Stall: CEB low holds data and valid
        opmode = 2'b00; bmux0 = 18'h00005; invld = 1'b1;
        tick();
        tick();
        chk("stall_pre_bcout", 32'(r_bcout), 32'h5);
        ceb = 1'b0; invld = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bmux0 = 18'(i);
            tick();
            chk("stall_bcout", 32'(r_bcout), 32'h5);
            chk("stall_vld",   32'(r_vld),   32'h1);
        end
        ceb = 1'b1;
        tick();
        chk("stall_release_bcout", 32'(r_bcout), 32'h3);
        chk("stall_release_vld",   32'(r_vld),   32'h0);
        chk_all("stall_release");

        // Combinational instance follows B_MUX0 without a clock edge
        opmode = 2'b01; din = 18'h00005; bmux0 = 18'h00010;
        #1;
        chk("comb_first",  32'(c_bcout), 32'h00015);
        bmux0 = 18'h00020;
        #1;
        chk("comb_second", 32'(c_bcout), 32'h00025);

        // Randomized traffic including corner operands and occasional reset
        for (int n = 0; n < 300; n++) begin
            rst    = ($urandom_range(0, 24) == 0);
            ced    = $urandom_range(0, 3) != 0;
            ceb    = $urandom_range(0, 3) != 0;
            ceop   = $urandom_range(0, 3) != 0;
            opmode = 2'($urandom_range(0, 3));
            invld  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       bmux0 = 18'h00000;
                1:       bmux0 = 18'h3FFFF;
                default: bmux0 = 18'($urandom);
            endcase
            din = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom);
            #1;
            chk("rand_comb", 32'(c_bcout), 32'(ref_pre(din, bmux0, opmode)));
            tick();
            chk_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
